udp_tx_rr_arbiter: RTL and testbench
====================================

// Module: udp_tx_rr_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter that shares one downstream AXI-Stream-style
//  buffer (the 64-bit shell FIFO) among NUM_SRC UDP TX requesters. Locks onto one
//  source from its first beat to its last beat, then rotates priority. Sits between
//  the per-flow packet builders and the shared TX FIFO in the UDP shell.
// PARAMETERS
//  NUM_SRC     4    number of requesters, >=2
//  DATA_WIDTH  64   payload width per beat
//  CNT_WIDTH   32   width of forwarded-packet counter
// PORTS
//  axis_clk      in   1                    single clock, all logic rising-edge
//  axis_rstn     in   1                    synchronous, active-low reset
//  s_axis_valid  in   NUM_SRC              per-source beat valid
//  s_axis_data   in   NUM_SRC*DATA_WIDTH   source i at [i*DATA_WIDTH +: DATA_WIDTH]
//  s_axis_last   in   NUM_SRC              per-source end-of-packet
//  s_axis_ready  out  NUM_SRC              per-source ready
//  m_axis_valid  out  1                    to shared FIFO
//  m_axis_data   out  DATA_WIDTH           to shared FIFO
//  m_axis_last   out  1                    to shared FIFO
//  m_axis_ready  in   1                    from shared FIFO (its !full)
//  grant_id      out  $clog2(NUM_SRC)      currently/last granted source
//  busy          out  1                    1 while in LOCKED
//  pkt_count     out  CNT_WIDTH            packets forwarded since reset
// BEHAVIOUR
//  - Reset (axis_rstn==0 at clk edge): state=IDLE, last_grant=NUM_SRC-1, grant_id=0,
//    pkt_count=0. Outputs while in reset/IDLE: m_axis_valid=0, s_axis_ready=0, busy=0.
//  - Reset mid-packet: abandons the packet; nothing further forwarded; downstream
//    sees a truncated packet (no last). Owners must reset downstream together.
//  - FSM IDLE: if any s_axis_valid, pick winner = first asserted index scanning
//    last_grant+1, +2, ... modulo NUM_SRC; register grant_id<=winner, go LOCKED.
//    No beat transferred in IDLE (1-cycle arbitration bubble per packet).
//  - FSM LOCKED (g=grant_id): combinational pass-through
//    m_axis_valid=s_axis_valid[g], m_axis_data/last=source g,
//    s_axis_ready[g]=m_axis_ready, s_axis_ready[others]=0.
//    Beat accepted when m_axis_valid&&m_axis_ready.
//    Accepted beat with last=1: last_grant<=g, pkt_count<=pkt_count+1 (wraps
//    modulo 2^CNT_WIDTH), go IDLE.
//    Source valid deasserting mid-packet: stay LOCKED indefinitely; no preemption.
//  - Single-beat packet (first beat has last=1): LOCKED for exactly one accepted
//    beat, then IDLE.
//  - Downstream full (m_axis_ready=0): hold state; source sees ready=0; no drop.
//  - Only valid on non-granted sources in LOCKED: ignored until return to IDLE.
//  - Throughput: packet of B beats with ready=1 occupies B+1 cycles.
//  - grant_id holds its value in IDLE (last winner) until next arbitration.
//  - m_axis_valid must not depend on m_axis_ready (AXI rule); ready may depend on valid.
// STRUCTURE
//  - Package udp_arb_pkg: typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
//    function rr_next(req, last) if shared with other arbiters.
//  - Sub-module rr_priority_pick #(N): combinational; in req[N], last[$clog2 N];
//    out found, idx. Implemented as doubled-vector rotate + find-first.
//  - Top: FSM, grant/last_grant registers, pkt_count, output mux.
// TESTING
//  1 Reset then src0,src2 valid same cycle, 3-beat pkts, ready=1 -> src0 first
//    (grant_id=0), then src2; m_axis_last on beats 3 and 6; pkt_count=2.
//  2 All 4 sources continuously valid, 2-beat pkts -> grant order 0,1,2,3,0,...;
//    each packet 3 cycles; no interleaving of beats between sources.
//  3 Src1 packet, m_axis_ready toggled 1,0,0,1,... -> no beat lost/duplicated;
//    s_axis_ready[1] mirrors m_axis_ready; data order 0xA0,0xA1,0xA2 intact.
//  4 Src3 drops valid mid-packet for 5 cycles while src0 valid -> stays LOCKED on
//    3, src0 ready=0 throughout; src0 served only after src3's last.
//  5 Assert axis_rstn=0 for 1 cycle mid-packet -> next cycle m_axis_valid=0,
//    busy=0, pkt_count=0; next arbitration favours src0.
//  6 CNT_WIDTH=4, send 17 single-beat packets -> pkt_count wraps 15->0, ends at 1.

Source files
------------

// File: rtl/udp_arb_pkg.sv
// Shared types and helpers for the UDP TX packet arbiters.
package udp_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage : udp_arb_pkg

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first asserted request scanning last+1, last+2, ... modulo N.
module rr_priority_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]                         req,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] last,
    output logic                                 found,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;

    // Doubling the vector turns the rotate into a plain shift; bit 0 of rot is index last+1.
    always_comb begin
        dbl   = {req, req};
        rot   = N'(dbl >> (32'(last) + 32'd1));
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (rot[i] && !found) begin
                found = 1'b1;
                idx   = IW'((32'(last) + 32'd1 + 32'(i)) % 32'(N));
            end
        end
    end

endmodule : rr_priority_pick

// File: rtl/udp_tx_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing the 64-bit TX FIFO among UDP packet builders.
module udp_tx_rr_arbiter
    import udp_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                          axis_clk,
    input  logic                          axis_rstn,
    input  logic [NUM_SRC-1:0]            s_axis_valid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_data,
    input  logic [NUM_SRC-1:0]            s_axis_last,
    output logic [NUM_SRC-1:0]            s_axis_ready,
    output logic                          m_axis_valid,
    output logic [DATA_WIDTH-1:0]         m_axis_data,
    output logic                          m_axis_last,
    input  logic                          m_axis_ready,
    output logic [$clog2(NUM_SRC)-1:0]    grant_id,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          pkt_count
);

    localparam int unsigned IW = $clog2(NUM_SRC);

    arb_state_t           state_q, state_d;
    logic [IW-1:0]        grant_q, grant_d;
    logic [IW-1:0]        last_q, last_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pick_found;
    logic [IW-1:0]        pick_idx;

    rr_priority_pick #(
        .N (NUM_SRC)
    ) u_pick (
        .req   (s_axis_valid),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge axis_clk) begin
        if (!axis_rstn) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_SRC - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are gated by reset so a packet in flight is cut off during the reset cycle.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        m_axis_valid = 1'b0;
        m_axis_data  = '0;
        m_axis_last  = 1'b0;
        s_axis_ready = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                m_axis_valid          = s_axis_valid[grant_q] && axis_rstn;
                m_axis_data           = s_axis_data[32'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
                m_axis_last           = s_axis_last[grant_q];
                s_axis_ready[grant_q] = m_axis_ready && axis_rstn;
                if (m_axis_valid && m_axis_ready && m_axis_last) begin
                    last_d  = grant_q;
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign grant_id  = grant_q;
    assign busy      = (state_q == ARB_LOCKED) && axis_rstn;
    assign pkt_count = cnt_q;

endmodule : udp_tx_rr_arbiter

// File: tb/tb_udp_tx_rr_arbiter.sv
// Directed bench for udp_tx_rr_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_udp_tx_rr_arbiter;

    localparam int unsigned NS = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned CW = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic [NS-1:0]    s_valid;
    logic [NS*DW-1:0] s_data;
    logic [NS-1:0]    s_last;
    logic [NS-1:0]    s_ready;
    logic             m_valid;
    logic [DW-1:0]    m_data;
    logic             m_last;
    logic             m_ready;
    logic [1:0]       gid;
    logic             busy;
    logic [CW-1:0]    cnt;
    logic [7:0]       beat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Source i presents {i, beat} so the forwarding source is visible in the data.
    always_comb begin
        for (int i = 0; i < int'(NS); i++) begin
            s_data[i*DW +: DW] = (64'(i) << 8) | 64'(beat);
        end
    end

    udp_tx_rr_arbiter #(
        .NUM_SRC    (NS),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .axis_clk     (clk),
        .axis_rstn    (rstn),
        .s_axis_valid (s_valid),
        .s_axis_data  (s_data),
        .s_axis_last  (s_last),
        .s_axis_ready (s_ready),
        .m_axis_valid (m_valid),
        .m_axis_data  (m_data),
        .m_axis_last  (m_last),
        .m_axis_ready (m_ready),
        .grant_id     (gid),
        .busy         (busy),
        .pkt_count    (cnt)
    );

    typedef struct {
        logic        rstn;
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic        mrdy;
        logic [7:0]  beat;
        logic        mv;
        logic        ml;
        logic [3:0]  srdy;
        logic [1:0]  gid;
        logic        busy;
        logic [3:0]  cnt;
        logic [63:0] dat;
    } vec_t;

    task automatic cmp(input string tag, input string what, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s act=%0h exp=%0h", tag, what, act, exp);
        end
    endtask

    // Drive after the falling edge, sample 1 ns later, well away from the rising edge.
    task automatic step(input logic r, input logic [3:0] v, input logic [3:0] l, input logic mr, input logic [7:0] b);
        @(negedge clk);
        rstn    = r;
        s_valid = v;
        s_last  = l;
        m_ready = mr;
        beat    = b;
        #1;
    endtask

    task automatic check(input string tag, input logic emv, input logic eml, input logic [3:0] esr,
                         input logic [1:0] eg, input logic eb, input logic [3:0] ec, input logic [63:0] ed);
        cmp(tag, "m_valid", 64'(m_valid), 64'(emv));
        cmp(tag, "s_ready", 64'(s_ready), 64'(esr));
        cmp(tag, "grant_id", 64'(gid), 64'(eg));
        cmp(tag, "busy", 64'(busy), 64'(eb));
        cmp(tag, "pkt_count", 64'(cnt), 64'(ec));
        if (emv) begin
            cmp(tag, "m_last", 64'(m_last), 64'(eml));
            cmp(tag, "m_data", m_data, ed);
        end
    endtask

    vec_t tbl[10];

    initial begin
        rstn = 1'b0; s_valid = '0; s_last = '0; m_ready = 1'b1; beat = '0;

        // Src0 and src2 request together, 3-beat packets.
        tbl[0] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 8'd0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 4'd0, 64'h0};
        tbl[1] = '{1'b1, 4'b0101, 4'b0000, 1'b1, 8'd0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 4'd0, 64'h0};
        tbl[2] = '{1'b1, 4'b0101, 4'b0000, 1'b1, 8'd0, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 4'd0, 64'h000};
        tbl[3] = '{1'b1, 4'b0101, 4'b0000, 1'b1, 8'd1, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 4'd0, 64'h001};
        tbl[4] = '{1'b1, 4'b0101, 4'b0101, 1'b1, 8'd2, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 4'd0, 64'h002};
        tbl[5] = '{1'b1, 4'b0101, 4'b0000, 1'b1, 8'd0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 4'd1, 64'h0};
        tbl[6] = '{1'b1, 4'b0101, 4'b0000, 1'b1, 8'd0, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 4'd1, 64'h200};
        tbl[7] = '{1'b1, 4'b0101, 4'b0000, 1'b1, 8'd1, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 4'd1, 64'h201};
        tbl[8] = '{1'b1, 4'b0101, 4'b0101, 1'b1, 8'd2, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 4'd1, 64'h202};
        tbl[9] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 8'd0, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 4'd2, 64'h0};

        step(1'b0, 4'b0000, 4'b0000, 1'b1, 8'd0);
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].rstn, tbl[i].vld, tbl[i].lst, tbl[i].mrdy, tbl[i].beat);
            check($sformatf("t1_v%0d", i), tbl[i].mv, tbl[i].ml, tbl[i].srdy, tbl[i].gid,
                  tbl[i].busy, tbl[i].cnt, tbl[i].dat);
        end

        // All sources continuously valid, 2-beat packets: strict rotation from src0.
        step(1'b0, 4'b0000, 4'b0000, 1'b1, 8'd0);
        for (int p = 0; p < 8; p++) begin
            step(1'b1, 4'hF, 4'h0, 1'b1, 8'd0);
            check("t2_arb", 1'b0, 1'b0, 4'b0000, (p == 0) ? 2'd0 : 2'((p - 1) % 4), 1'b0, 4'(p), 64'h0);
            step(1'b1, 4'hF, 4'h0, 1'b1, 8'd0);
            check("t2_b0", 1'b1, 1'b0, 4'(1 << (p % 4)), 2'(p % 4), 1'b1, 4'(p), 64'((p % 4) << 8));
            step(1'b1, 4'hF, 4'hF, 1'b1, 8'd1);
            check("t2_b1", 1'b1, 1'b1, 4'(1 << (p % 4)), 2'(p % 4), 1'b1, 4'(p), 64'(((p % 4) << 8) | 1));
        end

        // Src1 under downstream back-pressure 1,0,0,1,0,0,1.
        begin
            logic rp [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
            int b = 0;
            step(1'b1, 4'b0010, 4'b0000, 1'b1, 8'hA0);
            check("t3_arb", 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0, 4'd8, 64'h0);
            for (int k = 0; k < 7; k++) begin
                step(1'b1, 4'b0010, (b == 2) ? 4'b0010 : 4'b0000, rp[k], 8'(8'hA0 + b));
                check($sformatf("t3_c%0d", k), 1'b1, (b == 2), {2'b00, rp[k], 1'b0}, 2'd1, 1'b1, 4'd8,
                      64'h100 | 64'(8'hA0 + b));
                if (rp[k]) b++;
            end
            step(1'b1, 4'b0000, 4'b0000, 1'b1, 8'd0);
            check("t3_done", 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 4'd9, 64'h0);
        end

        // Src3 stalls mid-packet while src0 waits; no preemption.
        step(1'b1, 4'b1001, 4'b0000, 1'b1, 8'd0);
        check("t4_arb", 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 4'd9, 64'h0);
        step(1'b1, 4'b1001, 4'b0000, 1'b1, 8'd0);
        check("t4_b0", 1'b1, 1'b0, 4'b1000, 2'd3, 1'b1, 4'd9, 64'h300);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 4'b0001, 4'b0000, 1'b1, 8'd0);
            check($sformatf("t4_gap%0d", k), 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1, 4'd9, 64'h0);
        end
        step(1'b1, 4'b1001, 4'b1001, 1'b1, 8'd1);
        check("t4_b1", 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, 4'd9, 64'h301);
        step(1'b1, 4'b0001, 4'b0001, 1'b1, 8'd0);
        check("t4_arb0", 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0, 4'd10, 64'h0);
        step(1'b1, 4'b0001, 4'b0001, 1'b1, 8'd0);
        check("t4_src0", 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 4'd10, 64'h000);

        // Reset asserted for one cycle in the middle of a src2 packet.
        step(1'b1, 4'b0100, 4'b0000, 1'b1, 8'd0);
        check("t5_arb", 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 4'd11, 64'h0);
        step(1'b1, 4'b0100, 4'b0000, 1'b1, 8'd0);
        check("t5_b0", 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 4'd11, 64'h200);
        step(1'b0, 4'b0111, 4'b0000, 1'b1, 8'd1);
        check("t5_inrst", 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 4'd11, 64'h0);
        step(1'b1, 4'b0111, 4'b0000, 1'b1, 8'd1);
        check("t5_after", 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 4'd0, 64'h0);
        step(1'b1, 4'b0111, 4'b0001, 1'b1, 8'd1);
        check("t5_src0", 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 4'd0, 64'h001);

        // 17 single-beat packets on a 4-bit counter: wraps 15 -> 0, ends at 1.
        step(1'b0, 4'b0000, 4'b0000, 1'b1, 8'd0);
        for (int k = 0; k < 17; k++) begin
            step(1'b1, 4'b0010, 4'b0010, 1'b1, 8'(k));
            check($sformatf("t6_arb%0d", k), 1'b0, 1'b0, 4'b0000, (k == 0) ? 2'd0 : 2'd1, 1'b0, 4'(k % 16), 64'h0);
            step(1'b1, 4'b0010, 4'b0010, 1'b1, 8'(k));
            check($sformatf("t6_pkt%0d", k), 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 4'(k % 16), 64'h100 | 64'(k));
        end
        step(1'b1, 4'b0000, 4'b0000, 1'b1, 8'd0);
        check("t6_end", 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 4'd1, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_udp_tx_rr_arbiter
